dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache with its controller FSM, sitting directly downstream of the memory stage and in front of main memory.
- Services one load/store per request from the memory stage. Hits complete in the request cycle; misses stall the pipeline while the controller writes back the victim line and refills it from memory.
- `stall` feeds the processor's pipeline-stall network.

---
 rtl/dcache_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with its miss controller.
// Hits complete in the request cycle. Misses write back a dirty victim, then refill the line from memory.
module dcache_ctrl #(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        cache_hit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 16 - INDEX_BITS - 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        COMPLETE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [LINES-1:0]        dirty_q, dirty_d;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [3:0][15:0]        data_q [LINES];

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [1:0]              req_off;
    logic                    req;
    logic                    hit;

    logic                    data_we;
    logic [1:0]              data_sel;
    logic [15:0]             data_wval;
    logic                    tag_we;

    assign req_idx = addr[INDEX_BITS+2:3];
    assign req_tag = addr[15:INDEX_BITS+3];
    assign req_off = addr[2:1];
    assign req     = rd | wr;
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Control state; an async reset invalidates every line and aborts any miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[req_idx][data_sel] <= data_wval;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        data_we   = 1'b0;
        data_sel  = req_off;
        data_wval = wdata;
        tag_we    = 1'b0;
        done      = 1'b0;
        cache_hit = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        err       = (rd & wr) | (req & addr[0]);

        case (state_q)
            IDLE: begin
                if (req && !err) begin
                    if (hit) begin
                        done      = 1'b1;
                        cache_hit = 1'b1;
                        if (wr) begin
                            data_we          = 1'b1;
                            dirty_d[req_idx] = 1'b1;
                        end
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = WB;
                        cnt_d   = '0;
                    end else begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
            end
            WB: begin
                mem_wr    = 1'b1;
                mem_addr  = {tag_q[req_idx], req_idx, cnt_q[1:0], 1'b0};
                mem_wdata = data_q[req_idx][cnt_q[1:0]];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(3)) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                // Reads issue on fill cycles 0..3; each returns MEM_LAT cycles later.
                if (cnt_q < CNT_W'(4)) begin
                    mem_rd   = 1'b1;
                    mem_addr = {req_tag, req_idx, cnt_q[1:0], 1'b0};
                end
                if (cnt_q >= CNT_W'(MEM_LAT)) begin
                    data_we   = 1'b1;
                    data_sel  = 2'(cnt_q - CNT_W'(MEM_LAT));
                    data_wval = mem_rdata;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MEM_LAT + 3)) begin
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    tag_we           = 1'b1;
                    state_d          = COMPLETE;
                    cnt_d            = '0;
                end
            end
            COMPLETE: begin
                done = 1'b1;
                if (wr) begin
                    data_we          = 1'b1;
                    dirty_d[req_idx] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        stall = req & ~done & ~err;
        rdata = (done & rd) ? data_q[req_idx][req_off] : 16'h0;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: miss/hit/eviction/error/reset sequences against a latency-2 memory model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic [15:0] rdata;
    logic        done;
    logic        stall;
    logic        cache_hit;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;

    dcache_ctrl #(.INDEX_BITS(5), .MEM_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .rd        (rd),
        .wr        (wr),
        .rdata     (rdata),
        .done      (done),
        .stall     (stall),
        .cache_hit (cache_hit),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Main memory: preset line contents until written; reads return two cycles after issue.
    logic [15:0] mem [32768];
    bit          wrote [32768];
    logic [15:0] p0_a = '0;
    logic [15:0] p1_a = '0;

    function automatic logic [15:0] init_word(input logic [15:0] a);
        logic [15:0] base;
        case ({a[15:3], 3'b000})
            16'h0100: base = 16'hA000;
            16'h8100: base = 16'hC000;
            16'h0208: base = 16'hD000;
            16'h4208: base = 16'hE000;
            16'h0300: base = 16'hF000;
            16'h12F8: base = 16'h7000;
            default:  base = 16'h0000;
        endcase
        return base | {14'b0, a[2:1]};
    endfunction

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr[15:1]]   <= mem_wdata;
            wrote[mem_addr[15:1]] <= 1'b1;
        end
        p0_a <= mem_addr;
        p1_a <= p0_a;
    end

    assign mem_rdata = wrote[p1_a[15:1]] ? mem[p1_a[15:1]] : init_word(p1_a);

    task automatic chk(input string tg, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tg, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tg);
        chk({tg, " done"},   16'(done), 16'h0);
        chk({tg, " stall"},  16'(stall), 16'h0);
        chk({tg, " err"},    16'(err), 16'h0);
        chk({tg, " mem_rd"}, 16'(mem_rd), 16'h0);
        chk({tg, " mem_wr"}, 16'(mem_wr), 16'h0);
        chk({tg, " rdata"},  rdata, 16'h0);
    endtask

    // Full miss: optional writeback of old_base with wbd, 4-word refill, completion on cycle 7 or 11.
    task automatic miss_txn(input string tg, input logic [15:0] a, input logic is_wr,
                            input logic [15:0] wd, input logic dirty, input logic [15:0] old_base,
                            input logic [3:0][15:0] wbd, input logic [15:0] exp_rd);
        int fill0;
        int dn;
        logic exp_wr;
        logic exp_rdq;
        fill0 = dirty ? 5 : 1;
        dn    = dirty ? 11 : 7;
        addr  = a;
        rd    = ~is_wr;
        wr    = is_wr;
        wdata = wd;
        for (int c = 0; c <= dn; c++) begin
            @(negedge clk);
            exp_wr  = dirty && (c >= 1) && (c <= 4);
            exp_rdq = (c >= fill0) && (c < fill0 + 4);
            chk($sformatf("%s excl c%0d", tg, c), 16'(mem_rd & mem_wr), 16'h0);
            chk($sformatf("%s mem_wr c%0d", tg, c), 16'(mem_wr), 16'(exp_wr));
            chk($sformatf("%s mem_rd c%0d", tg, c), 16'(mem_rd), 16'(exp_rdq));
            if (exp_wr) begin
                chk($sformatf("%s wb_addr c%0d", tg, c), mem_addr, old_base + 16'(2 * (c - 1)));
                chk($sformatf("%s wb_data c%0d", tg, c), mem_wdata, wbd[c - 1]);
            end
            if (exp_rdq) begin
                chk($sformatf("%s rd_addr c%0d", tg, c), mem_addr,
                    {a[15:3], 3'b000} + 16'(2 * (c - fill0)));
            end
            if (c < dn) begin
                chk($sformatf("%s stall c%0d", tg, c), 16'(stall), 16'h1);
                chk($sformatf("%s done c%0d", tg, c), 16'(done), 16'h0);
            end else begin
                chk($sformatf("%s done c%0d", tg, c), 16'(done), 16'h1);
                chk($sformatf("%s hit c%0d", tg, c), 16'(cache_hit), 16'h0);
                chk($sformatf("%s stall c%0d", tg, c), 16'(stall), 16'h0);
                chk($sformatf("%s rdata c%0d", tg, c), rdata, exp_rd);
            end
            next_cycle();
        end
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic hit_txn(input string tg, input logic [15:0] a, input logic is_wr,
                           input logic [15:0] wd, input logic [15:0] exp_rd);
        addr  = a;
        rd    = ~is_wr;
        wr    = is_wr;
        wdata = wd;
        @(negedge clk);
        chk({tg, " done"},   16'(done), 16'h1);
        chk({tg, " hit"},    16'(cache_hit), 16'h1);
        chk({tg, " stall"},  16'(stall), 16'h0);
        chk({tg, " rdata"},  rdata, exp_rd);
        chk({tg, " mem_rd"}, 16'(mem_rd), 16'h0);
        chk({tg, " mem_wr"}, 16'(mem_wr), 16'h0);
        next_cycle();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic err_txn(input string tg, input logic [15:0] a, input logic r, input logic w);
        addr  = a;
        rd    = r;
        wr    = w;
        wdata = 16'hFFFF;
        @(negedge clk);
        chk({tg, " err"},    16'(err), 16'h1);
        chk({tg, " done"},   16'(done), 16'h0);
        chk({tg, " stall"},  16'(stall), 16'h0);
        chk({tg, " hit"},    16'(cache_hit), 16'h0);
        chk({tg, " mem_rd"}, 16'(mem_rd), 16'h0);
        chk({tg, " mem_wr"}, 16'(mem_wr), 16'h0);
        next_cycle();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    // Reset lands inside the second fill cycle; the refill must then restart from scratch.
    task automatic reset_mid_fill(input string tg, input logic [15:0] a, input logic [15:0] exp_rd);
        logic [3:0][15:0] none;
        none = '0;
        addr = a;
        rd   = 1'b1;
        wr   = 1'b0;
        next_cycle();
        next_cycle();
        chk({tg, " mem_rd pre"}, 16'(mem_rd), 16'h1);
        chk({tg, " addr pre"},   mem_addr, {a[15:3], 3'b010});
        #2;
        rst = 1'b0;
        rd  = 1'b0;
        #1;
        chk({tg, " mem_rd async"}, 16'(mem_rd), 16'h0);
        chk({tg, " mem_wr async"}, 16'(mem_wr), 16'h0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_quiet({tg, " idle"});
        next_cycle();
        miss_txn({tg, " refetch"}, a, 1'b0, 16'h0, 1'b0, 16'h0, none, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0][15:0] none;
        none  = '0;
        rst   = 1'b0;
        addr  = '0;
        wdata = '0;
        rd    = 1'b0;
        wr    = 1'b0;

        @(negedge clk);
        chk_quiet("in_reset");
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_quiet("post_reset");
        next_cycle();

        miss_txn("clean_miss", 16'h0104, 1'b0, 16'h0, 1'b0, 16'h0, none, 16'hA002);
        hit_txn("hit_rd", 16'h0106, 1'b0, 16'h0, 16'hA003);
        hit_txn("hit_wr", 16'h0102, 1'b1, 16'hBEEF, 16'h0000);
        miss_txn("dirty_miss", 16'h8102, 1'b0, 16'h0, 1'b1, 16'h0100,
                 {16'hA003, 16'hA002, 16'hBEEF, 16'hA000}, 16'hC001);

        miss_txn("write_miss", 16'h0208, 1'b1, 16'h1234, 1'b0, 16'h0, none, 16'h0000);
        hit_txn("write_miss_rd", 16'h0208, 1'b0, 16'h0, 16'h1234);
        miss_txn("evict_wm", 16'h4208, 1'b0, 16'h0, 1'b1, 16'h0208,
                 {16'hD003, 16'hD002, 16'hD001, 16'h1234}, 16'hE000);

        err_txn("err_rdwr", 16'h8106, 1'b1, 1'b1);
        err_txn("err_odd", 16'h0101, 1'b1, 1'b0);
        hit_txn("post_err", 16'h8106, 1'b0, 16'h0, 16'hC003);

        reset_mid_fill("rst_idx0", 16'h0300, 16'hF000);
        reset_mid_fill("rst_top", 16'h12FA, 16'h7001);
        hit_txn("top_hit", 16'h12FE, 1'b0, 16'h0, 16'h7003);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
